// File: rtl/ov7670_downsampler.sv
// ov7670_downsampler - decimates an RGB565 camera frame to 8-bit grey words with linear addresses.
// Define OV_GRAY_WEIGHTED_EN for (2R+5G+B)/8 grey; otherwise the expanded green channel is used.
module ov7670_downsampler #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int DS     = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       pixel,
  input  logic              pixelReady,
  input  logic              vsync,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              overflow
);

  localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int ROW_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int ENT_W = 8 + ADDR_W;

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               pr_q, vs_q;
  logic               s1_valid_q, s1_valid_d;
  logic [7:0]         s1_data_q, s1_data_d;
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
  logic               ovf_q, ovf_d;
  logic               fd_q, fd_d;
  logic               flush;

  logic [ENT_W-1:0]   mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;
  logic               push, pop, can_push;
  logic [ENT_W-1:0]   head;

  logic               pix_edge, vs_edge, keep;
  logic [7:0]         g8, grey;

  assign pix_edge = pixelReady & ~pr_q;
  assign vs_edge  = vsync & ~vs_q;
  assign keep     = ((col_q & COL_W'(DS-1)) == '0) && ((row_q & ROW_W'(DS-1)) == '0);

  assign g8 = {pixel[10:5], pixel[10:9]};
`ifdef OV_GRAY_WEIGHTED_EN
  logic [7:0]  r8, b8;
  logic [10:0] gsum;
  assign r8   = {pixel[15:11], pixel[15:13]};
  assign b8   = {pixel[4:0], pixel[4:2]};
  assign gsum = 11'({r8, 1'b0}) + 11'({g8, 2'b0}) + 11'(g8) + 11'(b8);
  assign grey = gsum[10:3];
`else
  logic unused_rb;
  assign unused_rb = ^{pixel[15:11], pixel[4:0]};
  assign grey      = g8;
`endif

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign can_push  = (count_q != 2'd2) || pop;
  // A flush discards whatever stage 1 is holding as well as the FIFO.
  assign push      = s1_valid_q && can_push && !flush;
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? head[ENT_W-1:ADDR_W] : 8'd0;
  assign out_addr  = out_valid ? head[ADDR_W-1:0] : '0;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    s1_addr_d  = s1_addr_q;
    ovf_d      = ovf_q;
    fd_d       = 1'b0;
    flush      = 1'b0;

    if (s1_valid_q && !can_push) ovf_d = 1'b1;

    case (state_q)
      WAIT_FRAME: begin
        if (vs_edge) begin
          state_d = ACTIVE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ACTIVE, DRAIN: begin
        if (vs_edge) begin
          state_d = ACTIVE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          ovf_d   = 1'b1;
          flush   = 1'b1;
        end else if (state_q == ACTIVE) begin
          if (pix_edge) begin
            if (keep) begin
              s1_valid_d = 1'b1;
              s1_data_d  = grey;
              s1_addr_d  = addr_q;
              addr_d     = addr_q + ADDR_W'(1);
            end
            if (col_q == COL_W'(SRC_W-1)) begin
              col_d = '0;
              if (row_q == ROW_W'(SRC_H-1)) begin
                row_d   = '0;
                state_d = DRAIN;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end else if (count_q == 2'd0 && !s1_valid_q) begin
          fd_d    = 1'b1;
          state_d = WAIT_FRAME;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= WAIT_FRAME;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      pr_q       <= 1'b0;
      vs_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= 8'd0;
      s1_addr_q  <= '0;
      ovf_q      <= 1'b0;
      fd_q       <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      pr_q       <= pixelReady;
      vs_q       <= vsync;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_addr_q  <= s1_addr_d;
      ovf_q      <= ovf_d;
      fd_q       <= fd_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + 2'(push) - 2'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {s1_data_q, s1_addr_q};
  end

endmodule

// File: tb/tb_ov7670_downsampler.sv
// tb_ov7670_downsampler - scoreboard bench for ov7670_downsampler on a reduced 64x32 frame.
module tb_ov7670_downsampler;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int DS = 8;
  localparam int AW = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   pixel = 16'h0000;
  logic          pixelReady = 1'b0;
  logic          vsync = 1'b0;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          frame_done;
  logic          overflow;

  always #5 clock = ~clock;

  ov7670_downsampler #(.SRC_W(W), .SRC_H(H), .DS(DS), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .pixel(pixel), .pixelReady(pixelReady), .vsync(vsync),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .overflow(overflow)
  );

  int total = 0;
  int bad = 0;
  int fd_count = 0;
  int exp_addr = 0;
  int hold_limit = -1;
  bit suppress = 1'b0;
  logic [AW+7:0] sb[$];
  logic [AW+7:0] mon_e;

  logic [15:0] vec_pix[4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
`ifdef OV_GRAY_WEIGHTED_EN
  logic [7:0]  vec_exp[4] = '{8'h3F, 8'h9F, 8'h1F, 8'h82};
`else
  logic [7:0]  vec_exp[4] = '{8'h00, 8'hFF, 8'h00, 8'h82};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (frame_done) fd_count++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got addr %0d data %0h expected no word", out_addr, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("word", {13'd0, out_data, out_addr}, {13'd0, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic send(input int r, input int c, input logic [15:0] d, input int hold, input logic [7:0] e);
    if ((r % DS == 0) && (c % DS == 0)) begin
      if (!suppress && (hold_limit < 0 || exp_addr < hold_limit)) sb.push_back({e, AW'(exp_addr)});
      exp_addr++;
    end
    pixel = d;
    pixelReady = 1'b1;
    repeat (hold) tick();
    pixelReady = 1'b0;
    tick();
  endtask

  task automatic run(input int r0, input int c0, input int r1, input int nc, input int mode);
    for (int r = r0; r < r1; r++) begin
      for (int c = (r == r0) ? c0 : 0; c < nc; c++) begin
        logic [15:0] d;
        logic [7:0]  e;
        if (mode == 0) begin
          d = 16'hFFFF; e = 8'hFF;
        end else if ((r % DS == 0) && (c % DS == 0)) begin
          d = vec_pix[exp_addr % 4]; e = vec_exp[exp_addr % 4];
        end else begin
          d = 16'h1234; e = 8'h00;
        end
        send(r, c, d, 1, e);
      end
    end
  endtask

  task automatic wait_fd(input int n);
    for (int i = 0; i < 200 && fd_count < n; i++) tick();
    repeat (3) tick();
    chk("frame_done_count", fd_count, n);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b1;
    tick();

    // Frame 1: all-white frame
    vsync_pulse();
    exp_addr = 0;
    run(0, 0, H, W, 0);
    wait_fd(1);
    chk("f1_ovf", overflow, 0);
    chk("f1_addr_end", exp_addr, (W/DS)*(H/DS));

    // Frame 2: colour vectors, latency on the first pixel, held pixelReady on the second
    vsync_pulse();
    exp_addr = 1;
    sb.push_back({vec_exp[0], AW'(0)});
    pixel = 16'hF800;
    pixelReady = 1'b1;
    tick();
    chk("lat_1clk_valid", out_valid, 0);
    tick();
    chk("lat_2clk_valid", out_valid, 1);
`ifdef OV_GRAY_WEIGHTED_EN
    chk("red_data", out_data, 8'h3F);
`else
    chk("red_data", out_data, 8'h00);
`endif
    pixelReady = 1'b0;
    tick();
    send(0, 1, 16'h1234, 5, 8'h00);
    run(0, 2, H, W, 1);
    wait_fd(2);
    chk("f2_ovf", overflow, 0);

    // Frame 3: downstream stalled across the first kept line
    vsync_pulse();
    exp_addr = 0;
    out_ready = 1'b0;
    hold_limit = 2;
    run(0, 0, 1, W, 0);
    chk("stall_held_valid", out_valid, 1);
    chk("stall_head_addr", out_addr, 0);
    chk("stall_ovf", overflow, 1);
    hold_limit = -1;
    out_ready = 1'b1;
    run(1, 0, H, W, 0);
    wait_fd(3);
    chk("f3_ovf_sticky", overflow, 1);

    // Frame 4: aborted by vsync mid-frame with words pending in the FIFO
    vsync_pulse();
    chk("ovf_cleared", overflow, 0);
    exp_addr = 0;
    run(0, 0, 16, W, 0);
    repeat (3) tick();
    out_ready = 1'b0;
    suppress = 1'b1;
    run(16, 0, 17, 9, 0);
    repeat (2) tick();
    chk("abort_pending_valid", out_valid, 1);
    vsync_pulse();
    chk("abort_flushed", out_valid, 0);
    chk("abort_ovf", overflow, 1);
    suppress = 1'b0;
    out_ready = 1'b1;

    // Frame 5: started by the aborting vsync, addresses restart at 0
    exp_addr = 0;
    run(0, 0, H, W, 0);
    wait_fd(4);
    chk("f5_ovf_sticky", overflow, 1);

    // Frame 6: reset pulsed mid-frame, then pixels without vsync are ignored
    vsync_pulse();
    exp_addr = 0;
    run(0, 0, 10, W, 0);
    repeat (4) tick();
    chk("pre_reset_sb", sb.size(), 0);
    reset = 1'b0;
    tick();
    check_idle("midreset");
    tick();
    reset = 1'b1;
    tick();
    suppress = 1'b1;
    run(0, 0, 2, W, 0);
    repeat (4) tick();
    chk("post_reset_valid", out_valid, 0);
    chk("post_reset_fd", fd_count, 4);
    suppress = 1'b0;

    // Frame 7: normal frame after reset
    vsync_pulse();
    exp_addr = 0;
    run(0, 0, H, W, 0);
    wait_fd(5);
    chk("f7_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
